// File: rtl/icap_write_ctrl.sv
// Purpose: sequences decrypted bitstream words from the AES FIFO into the ICAPE2 X32 write port.
// Latency: 1 cycle from accepted word to icap_i/icap_csib; one word per cycle, no buffering.
// Backpressure: s_ready=1 in IDLE/SYNC, 0 in DONE/ERR and during a clear pulse.
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   s_data/s_valid/s_ready    word stream from fifo128to32 (s_ready drives its read_en)
//   clear                     1-cycle abort/acknowledge pulse, returns to IDLE
//   icap_i/icap_csib/icap_rdwrb  ICAPE2 X32 write interface (csib active low, rdwrb tied 0)
//   busy/synced/done/timeout_err status for the SoC
//   word_count                words written to ICAP this session, saturating
// Optional feature: define ICAP_TIMEOUT_EN to abort a stalled session after
// TIMEOUT_CYCLES consecutive idle cycles in SYNC.
module icap_write_ctrl #(
  parameter logic [31:0] SYNC_WORD      = 32'hAA995566,
  parameter logic [31:0] DESYNC_HDR     = 32'h30008001,
  parameter logic [31:0] DESYNC_CMD     = 32'h0000000D,
  parameter bit          BITSWAP        = 1'b1,
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             clear,
  output logic [31:0]      icap_i,
  output logic             icap_csib,
  output logic             icap_rdwrb,
  output logic             busy,
  output logic             synced,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DONE, S_ERR} state_t;

  state_t      state, state_nxt;
  logic        hdr_seen, hdr_seen_nxt;  // last word written was DESYNC_HDR
  logic        xfer;
  logic        wr;
  logic        timeout_hit;
  logic [31:0] swapped;

  // 7-series ICAP expects each byte bit-reversed relative to bus order.
  always_comb begin
    swapped = s_data;
    if (BITSWAP) begin
      for (int k = 0; k < 4; k++) begin
        for (int b = 0; b < 8; b++) begin
          swapped[8*k+b] = s_data[8*k+7-b];
        end
      end
    end
  end

`ifdef ICAP_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt;

  // Counts consecutive s_valid=0 cycles in SYNC; any transfer restarts it.
  always_ff @(posedge clk) begin
    if (rst || clear || (state != S_SYNC) || s_valid) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

  assign timeout_hit = (state == S_SYNC) && !s_valid && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = (state == S_ERR);
`else
  // Timeout compiled out: parameter kept so instantiations stay identical.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    hdr_seen_nxt = hdr_seen;
    wr           = 1'b0;
    // clear blocks acceptance in its own cycle so no word is lost mid-abort.
    s_ready      = ((state == S_IDLE) || (state == S_SYNC)) && !clear;
    xfer         = s_valid && s_ready;
    if (clear) begin
      state_nxt    = S_IDLE;
      hdr_seen_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Pre-sync padding is silently dropped.
          if (xfer && (s_data == SYNC_WORD)) begin
            wr           = 1'b1;
            hdr_seen_nxt = 1'b0;
            state_nxt    = S_SYNC;
          end
        end
        S_SYNC: begin
          if (xfer) begin
            wr           = 1'b1;
            hdr_seen_nxt = (s_data == DESYNC_HDR);
            if (hdr_seen && (s_data == DESYNC_CMD)) begin
              state_nxt = S_DONE;
            end
          end else if (timeout_hit) begin
            state_nxt = S_ERR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      hdr_seen   <= 1'b0;
      icap_i     <= '0;
      icap_csib  <= 1'b1;
      word_count <= '0;
    end else begin
      state     <= state_nxt;
      hdr_seen  <= hdr_seen_nxt;
      icap_csib <= !wr;
      icap_i    <= wr ? swapped : '0;
      if (clear) begin
        word_count <= '0;
      end else if (wr) begin
        if (state == S_IDLE) begin
          word_count <= CNT_W'(1);
        end else if (word_count != '1) begin
          word_count <= word_count + CNT_W'(1);
        end
      end
    end
  end

  assign icap_rdwrb = 1'b0;
  assign busy       = (state == S_SYNC);
  assign synced     = (state == S_SYNC);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_icap_write_ctrl.sv
module tb_icap_write_ctrl;
  localparam logic [31:0] SYNC_W = 32'hAA995566;
  localparam logic [31:0] HDR_W  = 32'h30008001;
  localparam logic [31:0] CMD_W  = 32'h0000000D;
  localparam int          TMO    = 1024;
  localparam int          CW     = 24;
  localparam longint      CNT_MAX = (64'd1 << CW) - 1;

  localparam int M_IDLE = 0, M_SESSION = 1, M_DONE = 2, M_ERR = 3;

  logic          clk = 1'b0;
  logic          rst, s_valid, clear;
  logic [31:0]   s_data;
  logic          s_ready, icap_csib, icap_rdwrb, busy, synced, done, timeout_err;
  logic [31:0]   icap_i;
  logic [CW-1:0] word_count;

  always #5 clk = ~clk;

  icap_write_ctrl #(
    .BITSWAP        (1'b1),
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .clear       (clear),
    .icap_i      (icap_i),
    .icap_csib   (icap_csib),
    .icap_rdwrb  (icap_rdwrb),
    .busy        (busy),
    .synced      (synced),
    .done        (done),
    .timeout_err (timeout_err),
    .word_count  (word_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-wise bit reversal using the streaming operator.
  function automatic logic [31:0] ref_swap(input logic [31:0] w);
    logic [31:0] r;
    logic [7:0]  by, rb;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      by = w[8*k +: 8];
      rb = {<<{by}};
      r[8*k +: 8] = rb;
    end
    return r;
  endfunction

  // Behavioural model: session mode, last-header flag, idle run, counts.
  int          m_mode = M_IDLE;
  bit          m_hdr  = 1'b0;
  int          m_idle = 0;
  longint      m_cnt  = 0;
  logic [31:0] m_i    = '0;
  logic        m_csib = 1'b1;
  bit          m_live = 1'b0;

  function automatic bit m_ready();
    return ((m_mode == M_IDLE) || (m_mode == M_SESSION)) && !clear;
  endfunction

  always @(posedge clk) begin : model
    bit wrote;
    bit acc;
    wrote = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_hdr = 1'b0; m_idle = 0; m_cnt = 0; m_live = 1'b1;
    end else if (m_live) begin
      acc = s_valid && m_ready();
      if (clear) begin
        m_mode = M_IDLE; m_cnt = 0; m_hdr = 1'b0; m_idle = 0;
      end else if (m_mode == M_IDLE) begin
        if (acc && s_data == SYNC_W) begin
          wrote = 1'b1; m_cnt = 1; m_mode = M_SESSION; m_hdr = 1'b0; m_idle = 0;
        end
      end else if (m_mode == M_SESSION) begin
        if (acc) begin
          wrote = 1'b1;
          if (m_cnt < CNT_MAX) m_cnt++;
          if (m_hdr && s_data == CMD_W) m_mode = M_DONE;
          m_hdr  = (s_data == HDR_W);
          m_idle = 0;
        end else begin
          m_idle++;
`ifdef ICAP_TIMEOUT_EN
          if (m_idle == TMO) m_mode = M_ERR;
`endif
        end
      end
    end
    m_csib = !wrote;
    m_i    = wrote ? ref_swap(s_data) : 32'h0;
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("s_ready",     {31'b0, s_ready},     {31'b0, m_ready()});
      chk("icap_csib",   {31'b0, icap_csib},   {31'b0, m_csib});
      chk("icap_i",      icap_i,               m_i);
      chk("icap_rdwrb",  {31'b0, icap_rdwrb},  32'h0);
      chk("busy",        {31'b0, busy},        {31'b0, m_mode == M_SESSION});
      chk("synced",      {31'b0, synced},      {31'b0, m_mode == M_SESSION});
      chk("done",        {31'b0, done},        {31'b0, m_mode == M_DONE});
      chk("timeout_err", {31'b0, timeout_err}, {31'b0, m_mode == M_ERR});
      chk("word_count",  32'(word_count),      32'(m_cnt));
    end
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic c);
    s_valid = v; s_data = d; clear = c;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] pads [6];
    logic [31:0] w;
    int          r;
    int          sel;
    pads = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h000000BB, 32'h11220044};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; clear = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_csib",  {31'b0, icap_csib}, 32'h1);
    chk("rst_i",     icap_i, 32'h0);
    chk("rst_ready", {31'b0, s_ready}, 32'h1);
    chk("rst_count", 32'(word_count), 32'h0);
    chk("rst_done",  {31'b0, done}, 32'h0);
    chk("model_swap_sync", ref_swap(SYNC_W), 32'h5599AA66);
    chk("model_swap_cmd",  ref_swap(CMD_W),  32'h000000B0);
    rst = 1'b0;

    // Padding dropped, sync word written.
    foreach (pads[i]) begin
      cyc(1'b1, pads[i], 1'b0);
      chk("pad_csib", {31'b0, icap_csib}, 32'h1);
    end
    cyc(1'b1, SYNC_W, 1'b0);
    chk("sync_i",      icap_i, 32'h5599AA66);
    chk("sync_csib",   {31'b0, icap_csib}, 32'h0);
    chk("sync_synced", {31'b0, synced}, 32'h1);
    chk("sync_count",  32'(word_count), 32'h1);

    // 8 data words then DESYNC.
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      if (w == HDR_W) w = w ^ 32'h1;
      cyc(1'b1, w, 1'b0);
    end
    cyc(1'b1, HDR_W, 1'b0);
    chk("hdr_i", icap_i, 32'h0C000180);
    cyc(1'b1, CMD_W, 1'b0);
    chk("cmd_i",      icap_i, 32'h000000B0);
    chk("desync_done", {31'b0, done}, 32'h1);
    chk("desync_cnt",  32'(word_count), 32'd11);
    chk("desync_rdy",  {31'b0, s_ready}, 32'h0);
    cyc(1'b0, 32'h0, 1'b0);
    chk("done_csib", {31'b0, icap_csib}, 32'h1);
    chk("done_hold", 32'(word_count), 32'd11);
    cyc(1'b1, SYNC_W, 1'b1);
    chk("clr_done",  {31'b0, done}, 32'h0);
    chk("clr_count", 32'(word_count), 32'h0);
    chk("clr_csib",  {31'b0, icap_csib}, 32'h1);

    // Interrupted header does not finish; a gap does not break the pair.
    cyc(1'b1, SYNC_W, 1'b0);
    cyc(1'b1, HDR_W, 1'b0);
    cyc(1'b1, 32'h12345678, 1'b0);
    cyc(1'b1, CMD_W, 1'b0);
    chk("split_done", {31'b0, done}, 32'h0);
    chk("split_busy", {31'b0, busy}, 32'h1);
    chk("split_cnt",  32'(word_count), 32'd4);
    cyc(1'b1, HDR_W, 1'b0);
    repeat (3) cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b1, CMD_W, 1'b0);
    chk("gap_done", {31'b0, done}, 32'h1);
    chk("gap_cnt",  32'(word_count), 32'd6);
    cyc(1'b0, 32'h0, 1'b1);

    // Mid-stream gap, latency after resume, clear with a presented word.
    cyc(1'b1, SYNC_W, 1'b0);
    repeat (3) cyc(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 32'h0, 1'b0);
      chk("gap_csib", {31'b0, icap_csib}, 32'h1);
    end
    cyc(1'b1, 32'h01020408, 1'b0);
    chk("resume_i",    icap_i, 32'h80402010);
    chk("resume_csib", {31'b0, icap_csib}, 32'h0);
    chk("resume_err",  {31'b0, timeout_err}, 32'h0);
    cyc(1'b1, 32'hDEADBEEF, 1'b1);
    chk("clrw_csib", {31'b0, icap_csib}, 32'h1);
    chk("clrw_cnt",  32'(word_count), 32'h0);
    chk("clrw_busy", {31'b0, busy}, 32'h0);

`ifdef ICAP_TIMEOUT_EN
    cyc(1'b1, SYNC_W, 1'b0);
    repeat (TMO - 1) cyc(1'b0, 32'h0, 1'b0);
    chk("pre_timeout", {31'b0, timeout_err}, 32'h0);
    cyc(1'b0, 32'h0, 1'b0);
    chk("timeout_err", {31'b0, timeout_err}, 32'h1);
    chk("timeout_rdy", {31'b0, s_ready}, 32'h0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("tclr_cnt", 32'(word_count), 32'h0);
    chk("tclr_err", {31'b0, timeout_err}, 32'h0);
`endif

    // Reset mid-session.
    cyc(1'b1, SYNC_W, 1'b0);
    cyc(1'b1, $urandom, 1'b0);
    rst = 1'b1;
    cyc(1'b1, $urandom, 1'b0);
    chk("mrst_csib",   {31'b0, icap_csib}, 32'h1);
    chk("mrst_i",      icap_i, 32'h0);
    chk("mrst_cnt",    32'(word_count), 32'h0);
    chk("mrst_synced", {31'b0, synced}, 32'h0);
    chk("mrst_rdy",    {31'b0, s_ready}, 32'h1);
    rst = 1'b0;
    cyc(1'b1, HDR_W, 1'b0);
    cyc(1'b1, CMD_W, 1'b0);
    chk("post_rst_csib", {31'b0, icap_csib}, 32'h1);
    chk("post_rst_cnt",  32'(word_count), 32'h0);
    cyc(1'b1, SYNC_W, 1'b0);
    chk("resync_cnt", 32'(word_count), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r   = $urandom_range(0, 999);
      sel = $urandom_range(0, 6);
      rst = (r < 5);
      case (sel)
        0:       w = SYNC_W;
        1, 2:    w = HDR_W;
        3:       w = CMD_W;
        default: w = $urandom;
      endcase
      cyc(($urandom_range(0, 9) < 7), w, (r >= 5 && r < 30));
    end
    rst = 1'b0;
    repeat (3) cyc(1'b0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
